message_buffer: RTL
===================

MESSAGE_BUFFER -- requirements
Module: message_buffer

Interface
REQ-001 Parameter: DEPTH, default 6; number of character slots, one per HEX digit.
REQ-002 Parameter: SCROLL, default 1; when 1, appending to a full buffer scrolls; when 0, the new letter is dropped.
REQ-003 Port: Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: letter  input  6  decoded letter code from the morse decoder.
REQ-006 Port: commit  input  1  level signal; each rising edge appends `letter`.
REQ-007 Port: del  input  1  level signal; each rising edge removes the newest character.
REQ-008 Port: clr  input  1  level signal; while high, empties the buffer.
REQ-009 Port: chars  output  DEPTH*6  packed slots; slot 0 (LSBs) holds the oldest character.
REQ-010 Port: count  output  3  number of valid characters, 0..DEPTH.
REQ-011 Port: full / empty  output  1 each  asserted when count==DEPTH / count==0.
REQ-012 Port: overflow  output  1  one-cycle pulse when an append hits a full buffer.
REQ-013 Port: reject  output  1  one-cycle pulse when a committed code is greater than MAX_CODE.

Function
REQ-014 commit and del each SHALL be edge-detected against a registered previous sample; an action fires on the first Clock edge that samples the input high after it was low.
REQ-015 Outputs SHALL reflect an action immediately after the Clock edge on which it fires (latency 1 cycle from the input rise).
REQ-016 Append with count<DEPTH: slot[count] <= letter; count+1.
REQ-017 Append when full with SCROLL=1: slots shift down one (slot0 discarded), slot[DEPTH-1] <= letter, count unchanged, overflow pulses.
REQ-018 Append when full with SCROLL=0: no change, overflow pulses.
REQ-019 Append with letter>MAX_CODE: no change, reject pulses, no overflow pulse.
REQ-020 Delete with count>0: slot[count-1] <= BLANK; count-1.
REQ-021 Delete when empty: no effect, no pulse.
REQ-022 Commit and del firing on the same edge: the newest slot is replaced by letter; count unchanged.
REQ-023 Commit and del firing on the same edge with the buffer empty: behaves as a plain append.
REQ-024 A rejected letter during a simultaneous commit+del: no change; reject pulses.
REQ-025 clr high: all slots <= BLANK, count <= 0, overflow/reject low.
REQ-026 clr SHALL have priority over commit/del on the same edge.
REQ-027 Edge-detect registers SHALL keep tracking the inputs while clr is high, so a level still held when clr falls does not fire.
REQ-028 Slots at index >= count SHALL always hold BLANK.
REQ-029 count arithmetic SHALL saturate within 0..DEPTH and never wrap.

Reset
REQ-030 On Reset: all slots <= BLANK; count <= 0; empty=1; full=0; overflow=0; reject=0.
REQ-031 On Reset: edge-detect previous-sample registers <= 1, so an input held high through reset release does not fire.
REQ-032 Reset SHALL take effect asynchronously; release is sampled on Clock.

Structure
REQ-033 Package morse_pkg SHALL hold: CODE_W=6, MAX_CODE=6'd36, BLANK=6'h3F, and the DEPTH default.
REQ-034 One sub-module, rise_pulse (registered rising-edge detector, reset value 1), SHALL be instantiated for commit and del.
REQ-035 The slot array and count SHALL be a single registered process; overflow and reject SHALL be registered.

Verification
REQ-036 Reset, then commit rises 3 times with letters 1,2,3 -> chars slots 0..2 = 1,2,3; slots 3..5 = 3F; count=3.
REQ-037 Fill 6 slots (1..6), commit 7 with SCROLL=1 -> slots = 2..7, count=6, overflow high exactly 1 cycle.
REQ-038 Same sequence with SCROLL=0 -> slots unchanged at 1..6, overflow pulses.
REQ-039 count=2, commit and del rise on the same cycle with letter=9 -> slot1=9, count=2; then del on empty buffer -> no change.
REQ-040 commit held high across Reset release -> no append; letter=40 committed -> reject pulses, count unchanged.
REQ-041 clr asserted while commit rises -> buffer empty; commit still high when clr falls -> no append.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants for the morse message buffer: code width, legal code range,
// the blank-slot code and the default number of display slots.
package morse_pkg;

  localparam int                CODE_W    = 6;
  localparam int                CNT_W     = 3;
  localparam int                DEPTH_DEF = 6;
  localparam logic [CODE_W-1:0] MAX_CODE  = 6'd36;
  localparam logic [CODE_W-1:0] BLANK     = 6'h3F;

endpackage : morse_pkg

// File: rtl/rise_pulse.sv
// Registered rising-edge detector. The previous sample resets to 1 so a level
// already high when reset releases is not seen as a new edge.
module rise_pulse (
  input  logic Clock,
  input  logic Reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) prev_q <= 1'b1;
    else       prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule : rise_pulse

// File: rtl/message_buffer.sv
// Character buffer fed by the morse decoder: append on commit, delete newest on
// del, replace newest on both, clear on clr; slot 0 holds the oldest character.
module message_buffer
  import morse_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter bit SCROLL = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [CODE_W-1:0]       letter,
  input  logic                    commit,
  input  logic                    del,
  input  logic                    clr,
  output logic [DEPTH*CODE_W-1:0] chars,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    reject
);

  logic              commit_rise, del_rise;
  logic [CODE_W-1:0] slots_q [DEPTH];
  logic [CODE_W-1:0] slots_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d, last_idx;
  logic              ovf_q, ovf_d, rej_q, rej_d;
  logic              has_room, non_empty;

  rise_pulse u_commit_edge (.Clock(Clock), .Reset(Reset), .level_i(commit), .rise_o(commit_rise));
  rise_pulse u_del_edge    (.Clock(Clock), .Reset(Reset), .level_i(del),    .rise_o(del_rise));

  assign has_room  = count_q < CNT_W'(DEPTH);
  assign non_empty = count_q != '0;
  assign last_idx  = count_q - CNT_W'(1);

  // NOTE: every next-state signal is defaulted at the top of the block so no
  // path through the branches below can infer a latch.
  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    rej_d   = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) slots_d[i] = BLANK;
      count_d = '0;
    end else if (commit_rise) begin
      if (letter > MAX_CODE) begin
        rej_d = 1'b1;
      end else if (del_rise && non_empty) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == last_idx) slots_d[i] = letter;
      end else if (has_room) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == count_q) slots_d[i] = letter;
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
        if (SCROLL) begin
          for (int i = 0; i < DEPTH - 1; i++) slots_d[i] = slots_q[i+1];
          slots_d[DEPTH-1] = letter;
        end
      end
    end else if (del_rise && non_empty) begin
      for (int i = 0; i < DEPTH; i++)
        if (CNT_W'(i) == last_idx) slots_d[i] = BLANK;
      count_d = last_idx;
    end
  end

  // NOTE: the slot array is reset because empty slots must read as BLANK, not
  // as whatever the flops powered up with.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= BLANK;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) chars[i*CODE_W +: CODE_W] = slots_q[i];
  end

  assign count    = count_q;
  assign full     = count_q == CNT_W'(DEPTH);
  assign empty    = count_q == '0;
  assign overflow = ovf_q;
  assign reject   = rej_q;

endmodule : message_buffer
